// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory stage.
//   - funct3 access-size/sign encodings
//   - FSM state type
//   - byte-enable width
//   - small helpers for funct3 legality and alignment checks
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Stores only have B/H/W; the unsigned encodings exist for loads only.
    function automatic logic f3_valid(input logic [2:0] f3, input logic is_store);
        case (f3)
            F3_B, F3_H, F3_W: f3_valid = 1'b1;
            F3_BU, F3_HU:     f3_valid = !is_store;
            default:          f3_valid = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_H, F3_HU: misaligned = a[0];
            F3_W:        misaligned = (a != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational lane extract and sign/zero extension for loads.
// Ports:
//   rdata   in  32  raw bus read word
//   funct3  in  3   access size/sign
//   addr_lo in  2   low address bits selecting the lane
//   data    out 32  aligned, extended load result
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [7:0]  byte_lane [BE_W];
    logic [15:0] half_lane [2];
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_byte
            assign byte_lane[gi] = rdata[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign half_lane[gi] = rdata[16*gi +: 16];
        end
    endgenerate

    // A misaligned halfword (a[0]=1) simply uses the half chosen by a[1].
    assign sel_b = byte_lane[addr_lo];
    assign sel_h = half_lane[addr_lo[1]];

    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{24{sel_b[7]}}, sel_b};
            F3_BU:   data = {24'h0, sel_b};
            F3_H:    data = {{16{sel_h[15]}}, sel_h};
            F3_HU:   data = {16'h0, sel_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with a simple request/ack bus.
// Non-memory results pass through with one cycle latency; loads/stores
// hold the bus request until bus_ack or until TIMEOUT_CYCLES ACCESS cycles
// elapse, then produce a single writeback pulse (err on abort/illegal op).
// Ports:
//   clock, reset (async, active-low)
//   in_valid/in_ready, alu_result, store_data, mem_read, mem_write,
//   funct3, rd, reg_write                       -- from EX
//   bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_ack, bus_rdata -- memory bus
//   wb_valid, wb_rd, wb_data, wb_reg_write, err -- writeback
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     alu_result,
    input  logic [31:0]     store_data,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    output logic            bus_req,
    output logic            bus_we,
    output logic [31:0]     bus_addr,
    output logic [31:0]     bus_wdata,
    output logic [BE_W-1:0] bus_be,
    input  logic            bus_ack,
    input  logic [31:0]     bus_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [31:0]     wb_data,
    output logic            wb_reg_write,
    output logic            err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              bus_req_reg, bus_req_next;
    logic              bus_we_reg, bus_we_next;
    logic [31:0]       bus_addr_reg, bus_addr_next;
    logic [31:0]       bus_wdata_reg, bus_wdata_next;
    logic [BE_W-1:0]   bus_be_reg, bus_be_next;
    logic              wb_valid_reg, wb_valid_next;
    logic [4:0]        wb_rd_reg, wb_rd_next;
    logic [31:0]       wb_data_reg, wb_data_next;
    logic              wb_reg_write_reg, wb_reg_write_next;
    logic              err_reg, err_next;
    logic [2:0]        f3_reg, f3_next;
    logic [1:0]        addr_lo_reg, addr_lo_next;
    logic [4:0]        rd_reg, rd_next;
    logic              reg_write_reg, reg_write_next;
    logic              is_load_reg, is_load_next;

    logic [31:0]       byte_rep, half_rep, wdata_calc, load_data;
    logic [BE_W-1:0]   be_calc;
    logic              req_err;

    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_byte_rep
            assign byte_rep[8*gi +: 8] = store_data[7:0];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_rep
            assign half_rep[16*gi +: 16] = store_data[15:0];
        end
    endgenerate

    // Lane selection keys off funct3[1:0] so BU/HU loads get the same
    // byte enables as B/H. Shifts stay 4 bits wide (truncate, no wrap).
    always_comb begin
        be_calc    = {BE_W{1'b1}};
        wdata_calc = store_data;
        case (funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << alu_result[1:0];
                wdata_calc = byte_rep;
            end
            2'b01: begin
                be_calc    = 4'b0011 << {alu_result[1], 1'b0};
                wdata_calc = half_rep;
            end
            default: ;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign req_err = (mem_read && mem_write) || !f3_valid(funct3, mem_write)
                     || misaligned(funct3, alu_result[1:0]);
`else
    assign req_err = (mem_read && mem_write) || !f3_valid(funct3, mem_write);
`endif

    load_align u_load_align (
        .rdata   (bus_rdata),
        .funct3  (f3_reg),
        .addr_lo (addr_lo_reg),
        .data    (load_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            count_reg        <= '0;
            bus_req_reg      <= 1'b0;
            bus_we_reg       <= 1'b0;
            bus_addr_reg     <= '0;
            bus_wdata_reg    <= '0;
            bus_be_reg       <= '0;
            wb_valid_reg     <= 1'b0;
            wb_rd_reg        <= '0;
            wb_data_reg      <= '0;
            wb_reg_write_reg <= 1'b0;
            err_reg          <= 1'b0;
            f3_reg           <= '0;
            addr_lo_reg      <= '0;
            rd_reg           <= '0;
            reg_write_reg    <= 1'b0;
            is_load_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            count_reg        <= count_next;
            bus_req_reg      <= bus_req_next;
            bus_we_reg       <= bus_we_next;
            bus_addr_reg     <= bus_addr_next;
            bus_wdata_reg    <= bus_wdata_next;
            bus_be_reg       <= bus_be_next;
            wb_valid_reg     <= wb_valid_next;
            wb_rd_reg        <= wb_rd_next;
            wb_data_reg      <= wb_data_next;
            wb_reg_write_reg <= wb_reg_write_next;
            err_reg          <= err_next;
            f3_reg           <= f3_next;
            addr_lo_reg      <= addr_lo_next;
            rd_reg           <= rd_next;
            reg_write_reg    <= reg_write_next;
            is_load_reg      <= is_load_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        count_next        = count_reg;
        bus_req_next      = bus_req_reg;
        bus_we_next       = bus_we_reg;
        bus_addr_next     = bus_addr_reg;
        bus_wdata_next    = bus_wdata_reg;
        bus_be_next       = bus_be_reg;
        wb_valid_next     = 1'b0;
        wb_rd_next        = wb_rd_reg;
        wb_data_next      = wb_data_reg;
        wb_reg_write_next = 1'b0;
        err_next          = 1'b0;
        f3_next           = f3_reg;
        addr_lo_next      = addr_lo_reg;
        rd_next           = rd_reg;
        reg_write_next    = reg_write_reg;
        is_load_next      = is_load_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (!mem_read && !mem_write) begin
                        wb_valid_next     = 1'b1;
                        wb_rd_next        = rd;
                        wb_data_next      = alu_result;
                        wb_reg_write_next = reg_write && (rd != 5'd0);
                    end else if (req_err) begin
                        wb_valid_next = 1'b1;
                        err_next      = 1'b1;
                        wb_rd_next    = rd;
                        wb_data_next  = '0;
                    end else begin
                        f3_next        = funct3;
                        addr_lo_next   = alu_result[1:0];
                        rd_next        = rd;
                        reg_write_next = reg_write;
                        is_load_next   = mem_read;
                        bus_req_next   = 1'b1;
                        bus_we_next    = mem_write;
                        bus_addr_next  = {alu_result[31:2], 2'b00};
                        bus_wdata_next = wdata_calc;
                        bus_be_next    = be_calc;
                        count_next     = '0;
                        state_next     = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (bus_ack) begin
                    bus_req_next      = 1'b0;
                    bus_we_next       = 1'b0;
                    wb_valid_next     = 1'b1;
                    wb_rd_next        = rd_reg;
                    wb_data_next      = is_load_reg ? load_data : 32'h0;
                    wb_reg_write_next = is_load_reg && reg_write_reg && (rd_reg != 5'd0);
                    count_next        = '0;
                    state_next        = IDLE;
                end else if (count_reg == CNT_LAST) begin
                    // Timeout: abandon the request and report it as an error.
                    bus_req_next  = 1'b0;
                    bus_we_next   = 1'b0;
                    wb_valid_next = 1'b1;
                    err_next      = 1'b1;
                    wb_rd_next    = rd_reg;
                    wb_data_next  = '0;
                    count_next    = '0;
                    state_next    = IDLE;
                end else begin
                    count_next = count_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready     = (state_reg == IDLE);
    assign bus_req      = bus_req_reg;
    assign bus_we       = bus_we_reg;
    assign bus_addr     = bus_addr_reg;
    assign bus_wdata    = bus_wdata_reg;
    assign bus_be       = bus_be_reg;
    assign wb_valid     = wb_valid_reg;
    assign wb_rd        = wb_rd_reg;
    assign wb_data      = wb_data_reg;
    assign wb_reg_write = wb_reg_write_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage. Expected writebacks are
// queued when a transaction is issued and popped when the DUT writes back.
module tb_mem_stage;
    import mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd = '0;
    logic        reg_write = 1'b0;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_reg_write;
    logic        err;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rw;
        logic        err;
        logic        dc;   // data is don't-care (stores, errors)
    } exp_t;
    exp_t sb[$];

    mem_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .rd           (rd),
        .reg_write    (reg_write),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_be       (bus_be),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_reg_write (wb_reg_write),
        .err          (err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one EX result for exactly one cycle.
    task automatic drive(input logic [31:0] a, input logic [31:0] sd, input logic rd_op,
                         input logic wr_op, input logic [2:0] f3, input logic [4:0] r,
                         input logic rw);
        alu_result = a;
        store_data = sd;
        mem_read   = rd_op;
        mem_write  = wr_op;
        funct3     = f3;
        rd         = r;
        reg_write  = rw;
        in_valid   = 1'b1;
        tick();
        in_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        alu_result = 32'h55;
        rd = 5'd3;
        reg_write = 1'b1;
        tick();
        tick();
        total++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, bus_be, wb_valid, wb_rd, wb_data,
             wb_reg_write, err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h be=%b v=%b rd=%0d data=%h rw=%b err=%b want all 0",
                     bus_req, bus_we, bus_addr, bus_wdata, bus_be, wb_valid, wb_rd, wb_data, wb_reg_write, err);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        $display("txn reset: released");
    endtask

    task automatic test_passthrough();
        exp_t e;
        sb.push_back('{5'd5, 32'h0000_1234, 1'b1, 1'b0, 1'b0});
        drive(32'h0000_1234, 32'h0, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1);
        e = sb.pop_front();
        total++;
        if (wb_valid !== 1'b1 || wb_rd !== e.rd || wb_data !== e.data || wb_reg_write !== e.rw || err !== e.err) begin
            bad++;
            $display("FAIL pass_add: v=%b rd=%0d data=%h rw=%b err=%b want v=1 rd=%0d data=%h rw=%b err=%b",
                     wb_valid, wb_rd, wb_data, wb_reg_write, err, e.rd, e.data, e.rw, e.err);
        end
        $display("txn pass_add: rd=%0d data=%h rw=%b", wb_rd, wb_data, wb_reg_write);
        sb.push_back('{5'd0, 32'hDEAD_0001, 1'b0, 1'b0, 1'b0});
        drive(32'hDEAD_0001, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b1);
        e = sb.pop_front();
        total++;
        if (wb_valid !== 1'b1 || wb_rd !== e.rd || wb_data !== e.data || wb_reg_write !== e.rw || err !== e.err) begin
            bad++;
            $display("FAIL pass_x0: v=%b rd=%0d data=%h rw=%b err=%b want v=1 rd=%0d data=%h rw=%b err=%b",
                     wb_valid, wb_rd, wb_data, wb_reg_write, err, e.rd, e.data, e.rw, e.err);
        end
        $display("txn pass_x0: rd=%0d data=%h rw=%b", wb_rd, wb_data, wb_reg_write);
        tick();
        total++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL pass_pulse: v=%b rdy=%b want v=0 rdy=1", wb_valid, in_ready);
        end
    endtask

    task automatic run_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rdata, input logic [31:0] expd, input int dly);
        exp_t e;
        logic stable;
        logic [31:0] waddr;
        waddr = {a[31:2], 2'b00};
        sb.push_back('{5'd10, expd, 1'b1, 1'b0, 1'b0});
        drive(a, 32'h0, 1'b1, 1'b0, f3, 5'd10, 1'b1);
        total++;
        if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== waddr || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s_issue: req=%b we=%b addr=%h rdy=%b want req=1 we=0 addr=%h rdy=0",
                     nm, bus_req, bus_we, bus_addr, in_ready, waddr);
        end
        stable = 1'b1;
        for (int i = 1; i < dly; i++) begin
            bus_rdata = $urandom;
            tick();
            if (bus_req !== 1'b1 || bus_addr !== waddr || wb_valid !== 1'b0) stable = 1'b0;
        end
        if (dly > 1) begin
            total++;
            if (stable !== 1'b1) begin
                bad++;
                $display("FAIL %s_hold: req=%b addr=%h v=%b want req=1 addr=%h v=0",
                         nm, bus_req, bus_addr, wb_valid, waddr);
            end
        end
        bus_ack = 1'b1;
        bus_rdata = rdata;
        tick();
        bus_ack = 1'b0;
        bus_rdata = $urandom;
        e = sb.pop_front();
        total++;
        if (wb_valid !== 1'b1 || wb_rd !== e.rd || wb_data !== e.data || wb_reg_write !== e.rw ||
            err !== e.err || bus_req !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_done: v=%b rd=%0d data=%h rw=%b err=%b req=%b rdy=%b want v=1 rd=%0d data=%h rw=%b err=%b req=0 rdy=1",
                     nm, wb_valid, wb_rd, wb_data, wb_reg_write, err, bus_req, in_ready, e.rd, e.data, e.rw, e.err);
        end
        $display("txn %s: addr=%h data=%h", nm, a, wb_data);
    endtask

    task automatic test_load();
        run_load("lb",    F3_B,  32'h0000_0103, 32'h80FF_FFFF, 32'hFFFF_FF80, 3);
        run_load("lbu",   F3_BU, 32'h0000_0103, 32'h80FF_FFFF, 32'h0000_0080, 3);
        run_load("lh",    F3_H,  32'h0000_0102, 32'h80FF_1234, 32'hFFFF_80FF, 1);
        run_load("lhu",   F3_HU, 32'h0000_0102, 32'h80FF_1234, 32'h0000_80FF, 2);
        run_load("lb0",   F3_B,  32'h0000_0100, 32'h1234_567F, 32'h0000_007F, 1);
        run_load("lh0",   F3_H,  32'h0000_0100, 32'h1234_8001, 32'hFFFF_8001, 1);
        run_load("lw",    F3_W,  32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4);
    endtask

    task automatic run_store(input string nm, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input logic [3:0] be, input logic [31:0] wd);
        exp_t e;
        sb.push_back('{5'd9, 32'h0, 1'b0, 1'b0, 1'b1});
        drive(a, sd, 1'b0, 1'b1, f3, 5'd9, 1'b1);
        total++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== {a[31:2], 2'b00} ||
            bus_be !== be || bus_wdata !== wd) begin
            bad++;
            $display("FAIL %s_issue: req=%b we=%b addr=%h be=%b wdata=%h want req=1 we=1 addr=%h be=%b wdata=%h",
                     nm, bus_req, bus_we, bus_addr, bus_be, bus_wdata, {a[31:2], 2'b00}, be, wd);
        end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        e = sb.pop_front();
        total++;
        if (wb_valid !== 1'b1 || wb_rd !== e.rd || wb_reg_write !== e.rw || err !== e.err || bus_req !== 1'b0) begin
            bad++;
            $display("FAIL %s_done: v=%b rd=%0d rw=%b err=%b req=%b want v=1 rd=%0d rw=%b err=%b req=0",
                     nm, wb_valid, wb_rd, wb_reg_write, err, bus_req, e.rd, e.rw, e.err);
        end
        $display("txn %s: addr=%h be=%b wdata=%h", nm, a, be, wd);
    endtask

    task automatic test_store();
        run_store("sh", F3_H, 32'h0000_0202, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
        run_store("sb", F3_B, 32'h0000_0201, 32'h0000_0012, 4'b0010, 32'h1212_1212);
        run_store("sw", F3_W, 32'h0000_0200, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    endtask

    task automatic run_err(input string nm, input logic rd_op, input logic wr_op,
                           input logic [2:0] f3, input logic [31:0] a);
        exp_t e;
        sb.push_back('{5'd6, 32'h0, 1'b0, 1'b1, 1'b1});
        drive(a, 32'h1111_2222, rd_op, wr_op, f3, 5'd6, 1'b1);
        e = sb.pop_front();
        total++;
        if (wb_valid !== 1'b1 || wb_rd !== e.rd || wb_reg_write !== e.rw || err !== e.err || bus_req !== 1'b0) begin
            bad++;
            $display("FAIL %s: v=%b rd=%0d rw=%b err=%b req=%b want v=1 rd=%0d rw=%b err=%b req=0",
                     nm, wb_valid, wb_rd, wb_reg_write, err, bus_req, e.rd, e.rw, e.err);
        end
        tick();
        total++;
        if (err !== 1'b0 || wb_valid !== 1'b0 || bus_req !== 1'b0) begin
            bad++;
            $display("FAIL %s_pulse: err=%b v=%b req=%b want 0 0 0", nm, err, wb_valid, bus_req);
        end
        $display("txn %s: err reported", nm);
    endtask

    task automatic test_errors();
        run_err("both_rw",   1'b1, 1'b1, F3_W,   32'h0000_0400);
        run_err("bad_f3_ld", 1'b1, 1'b0, 3'b011, 32'h0000_0400);
        run_err("bad_f3_st", 1'b0, 1'b1, F3_BU,  32'h0000_0400);
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
        run_err("lw_misal", 1'b1, 1'b0, F3_W, 32'h0000_0101);
`else
        run_load("lw_misal", F3_W, 32'h0000_0101, 32'h1122_3344, 32'h1122_3344, 2);
`endif
    endtask

    task automatic test_timeout();
        int cnt;
        exp_t e;
        sb.push_back('{5'd4, 32'h0, 1'b0, 1'b1, 1'b1});
        drive(32'h0000_0300, 32'h0, 1'b1, 1'b0, F3_W, 5'd4, 1'b1);
        cnt = 0;
        while (bus_req === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        total++;
        if (cnt != 16) begin
            bad++;
            $display("FAIL timeout_len: req high %0d cycles want 16", cnt);
        end
        e = sb.pop_front();
        total++;
        if (wb_valid !== 1'b1 || err !== e.err || wb_rd !== e.rd || wb_reg_write !== e.rw || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout_done: v=%b err=%b rd=%0d rw=%b rdy=%b want v=1 err=1 rd=%0d rw=0 rdy=1",
                     wb_valid, err, wb_rd, wb_reg_write, in_ready, e.rd);
        end
        tick();
        total++;
        if (wb_valid !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse: v=%b err=%b want 0 0", wb_valid, err);
        end
        $display("txn timeout: aborted after %0d cycles", cnt);
    endtask

    task automatic test_ack_idle();
        logic seen;
        seen = 1'b0;
        bus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wb_valid !== 1'b0 || bus_req !== 1'b0 || err !== 1'b0) seen = 1'b1;
        end
        bus_ack = 1'b0;
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL ack_idle: spurious activity got 1 want 0");
        end
        $display("txn ack_idle: ignored");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic early;
        sb.push_back('{5'd11, 32'h0000_00AB, 1'b1, 1'b0, 1'b0});
        sb.push_back('{5'd7,  32'h0000_0077, 1'b1, 1'b0, 1'b0});
        drive(32'h0000_0500, 32'h0, 1'b1, 1'b0, F3_BU, 5'd11, 1'b1);
        // Upstream presents the next result while the stage is busy.
        alu_result = 32'h0000_0077;
        rd = 5'd7;
        reg_write = 1'b1;
        funct3 = F3_B;
        in_valid = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (wb_valid !== 1'b0 || in_ready !== 1'b0) early = 1'b1;
        end
        total++;
        if (early !== 1'b0) begin
            bad++;
            $display("FAIL b2b_busy: input accepted while busy got 1 want 0");
        end
        bus_ack = 1'b1;
        bus_rdata = 32'h0000_00AB;
        tick();
        bus_ack = 1'b0;
        e = sb.pop_front();
        total++;
        if (wb_valid !== 1'b1 || wb_rd !== e.rd || wb_data !== e.data || wb_reg_write !== e.rw) begin
            bad++;
            $display("FAIL b2b_load: v=%b rd=%0d data=%h rw=%b want v=1 rd=%0d data=%h rw=%b",
                     wb_valid, wb_rd, wb_data, wb_reg_write, e.rd, e.data, e.rw);
        end
        $display("txn b2b_load: rd=%0d data=%h", wb_rd, wb_data);
        tick();
        in_valid = 1'b0;
        e = sb.pop_front();
        total++;
        if (wb_valid !== 1'b1 || wb_rd !== e.rd || wb_data !== e.data || wb_reg_write !== e.rw) begin
            bad++;
            $display("FAIL b2b_pass: v=%b rd=%0d data=%h rw=%b want v=1 rd=%0d data=%h rw=%b",
                     wb_valid, wb_rd, wb_data, wb_reg_write, e.rd, e.data, e.rw);
        end
        $display("txn b2b_pass: rd=%0d data=%h", wb_rd, wb_data);
        tick();
    endtask

    task automatic test_reset_access();
        logic seen;
        drive(32'h0000_0600, 32'h0, 1'b1, 1'b0, F3_W, 5'd12, 1'b1);
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (bus_req !== 1'b0 || in_ready !== 1'b1 || wb_valid !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL rst_access: req=%b rdy=%b v=%b err=%b want req=0 rdy=1 v=0 err=0",
                     bus_req, in_ready, wb_valid, err);
        end
        tick();
        reset = 1'b1;
        seen = 1'b0;
        bus_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wb_valid !== 1'b0 || err !== 1'b0 || bus_req !== 1'b0) seen = 1'b1;
        end
        bus_ack = 1'b0;
        total++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_after: activity=%b rdy=%b want activity=0 rdy=1", seen, in_ready);
        end
        $display("txn rst_access: access abandoned");
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load();
        test_store();
        test_errors();
        test_misalign();
        test_timeout();
        test_ack_idle();
        test_back_to_back();
        test_reset_access();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum ACCESS cycles without bus_ack before abort.
REQ-002 The block SHALL have ports:
- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  EX result presented
- in_ready  out  1  stage can accept a result this cycle
- alu_result  in  32  ALU output: load/store address, or pass-through result
- store_data  in  32  rs2 value for stores
- mem_read  in  1  load operation
- mem_write  in  1  store operation
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rd  in  5  destination register
- reg_write  in  1  writes rd
- bus_req  out  1  memory request
- bus_we  out  1  write strobe
- bus_addr  out  32  word-aligned address {alu_result[31:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables
- bus_ack  in  1  request completed this cycle
- bus_rdata  in  32  read word, valid with bus_ack
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback value
- wb_reg_write  out  1  writeback enable
- err  out  1  one-cycle error pulse, coincident with wb_valid

Function
REQ-003 The FSM SHALL have states IDLE and ACCESS; in_ready SHALL be 1 exactly in IDLE.
REQ-004 In IDLE, in_valid with neither mem_read nor mem_write SHALL produce wb_valid=1, wb_data=alu_result, wb_rd=rd, wb_reg_write=reg_write on the next cycle (latency 1).
REQ-005 In IDLE, in_valid with exactly one of mem_read/mem_write SHALL latch all inputs, assert bus_req next cycle and enter ACCESS.
REQ-006 In ACCESS, bus_req, bus_we, bus_addr, bus_wdata and bus_be SHALL stay constant until bus_ack is sampled high; bus_ack outside ACCESS SHALL be ignored.
REQ-007 bus_ack in the first ACCESS cycle SHALL be legal; bus_req SHALL drop the cycle after bus_ack, wb_valid SHALL pulse that cycle, and the state SHALL return to IDLE (latency = cycles to ack + 1).
REQ-008 Loads SHALL select the byte/half lane by alu_result[1:0] and sign-extend (B, H) or zero-extend (BU, HU); LW SHALL pass bus_rdata unchanged.
REQ-009 Stores SHALL drive bus_be 0001<<a[1:0] (SB), 0011<<{a[1],1'b0} (SH), 1111 (SW), replicate the byte/half across bus_wdata, and complete with wb_reg_write=0.
REQ-010 wb_reg_write SHALL be 0 whenever wb_rd=0.
REQ-011 mem_read and mem_write both high SHALL issue no bus access and pulse err with wb_valid, wb_reg_write=0, one cycle later.
REQ-012 An ACCESS cycle counter SHALL, on reaching TIMEOUT_CYCLES without bus_ack, drop bus_req, pulse err with wb_valid, wb_reg_write=0, and return to IDLE.
REQ-013 Undefined funct3 SHALL be treated as the error of REQ-011.
REQ-014 in_valid while in_ready=0 SHALL be ignored; upstream holds its data.

Reset
REQ-015 While reset=0 every output SHALL be 0 except in_ready=1; state SHALL be IDLE and the counter 0.
REQ-016 Reset asserted mid-ACCESS SHALL drop bus_req immediately, with no wb_valid or err for the abandoned access.

Configuration
REQ-017 With MEM_MISALIGN_TRAP_EN defined, H/HU/SH with a[0]=1 or W/SW with a[1:0]!=0 SHALL issue no bus access and pulse err as in REQ-011.
REQ-018 Without MEM_MISALIGN_TRAP_EN, no check SHALL occur; lanes SHALL use the 4-bit truncated shifts of REQ-009, and err SHALL never come from alignment.

Structure
REQ-019 Package mem_pkg SHALL hold funct3 constants, the FSM state typedef and the bus_be width constant.
REQ-020 Load lane extract/extend SHALL be a combinational sub-module load_align.

Verification
REQ-021 ADD pass-through, alu_result=0x0000_1234, rd=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_reg_write=1.
REQ-022 LB at 0x103, bus_rdata=0x80FF_FFFF, ack after 3 cycles -> bus_addr=0x100, wb_data=0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-023 SH at 0x202, store_data=0xABCD -> bus_be=1100, bus_wdata=0xABCD_ABCD, bus_we=1, wb_reg_write=0.
REQ-024 No bus_ack for 16 ACCESS cycles -> bus_req drops, err=1 and wb_valid=1 together for one cycle, in_ready back to 1.
REQ-025 LW at 0x101: with MEM_MISALIGN_TRAP_EN -> no bus_req, err pulse; without -> bus_addr=0x100, normal completion.
REQ-026 reset=0 two cycles into ACCESS -> bus_req=0 at once, no wb_valid after release, in_ready=1.
